instr_sequencer: RTL

//  Fetch/decode/execute control sequencer for the 16-bit core. Fetches one instruction word per

---
 rtl/instr_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer
//  Description : Fetch/decode/execute control sequencer for the 16-bit core.
//                Fetches instruction words over a req/ack port, holds them in
//                the instruction register and drives opcode (A) plus enable (E)
//                into the downstream 4-to-16 opcode decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int                ADDR_W      = 12,
    parameter int                DATA_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [3:0]        HALT_OPCODE = 4'hF
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              RUN,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [3:0]        A,
    output logic              E,
    output logic [ADDR_W-1:0] OPERAND,
    input  logic              EXEC_DONE,
    input  logic              PC_LOAD,
    input  logic [ADDR_W-1:0] PC_LOAD_VAL,
    output logic              HALTED,
    output logic [15:0]       RETIRED
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    state_t              state_q,   state_d;
    logic [ADDR_W-1:0]   pc_q,      pc_d;
    logic [DATA_W-1:0]   ir_q,      ir_d;
    logic [3:0]          a_q,       a_d;
    logic                e_q,       e_d;
    logic                mem_req_q, mem_req_d;
    logic                halted_q,  halted_d;
    logic [15:0]         retired_q, retired_d;
    logic                run_q,     run_d;

    logic [3:0]          w_opcode;
    logic [ADDR_W-1:0]   w_pc_inc;

    assign w_opcode = ir_q[DATA_W-1 -: 4];
    assign w_pc_inc = pc_q + ADDR_W'(1);

    // Next-state and registered-output computation for the sequencer.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        retired_d = retired_q;
        run_d     = RUN;

        case (state_q)
            ST_IDLE: begin
                if (RUN) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Once started, a fetch always completes regardless of RUN.
                if (MEM_ACK) begin
                    ir_d    = MEM_RDATA;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // The halt opcode is consumed here so the decoder never sees it enabled.
                if (w_opcode == HALT_OPCODE) begin
                    pc_d    = w_pc_inc;
                    state_d = ST_HALT;
                end else begin
                    a_d     = w_opcode;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (EXEC_DONE) begin
                    pc_d      = PC_LOAD ? PC_LOAD_VAL : w_pc_inc;
                    retired_d = retired_q + 16'd1;
                    state_d   = RUN ? ST_FETCH : ST_IDLE;
                end
            end
            ST_HALT: begin
                // Resume only on a fresh RUN rising edge, not a level held since entry.
                if (RUN && !run_q) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // State-decoded outputs are computed from the next state so they are flop outputs.
        mem_req_d = (state_d == ST_FETCH);
        e_d       = (state_d == ST_EXEC);
        halted_d  = (state_d == ST_HALT);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= 4'h0;
            e_q       <= 1'b0;
            mem_req_q <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= 16'h0000;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            e_q       <= e_d;
            mem_req_q <= mem_req_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
            run_q     <= run_d;
        end
    end

    assign MEM_REQ  = mem_req_q;
    assign MEM_ADDR = pc_q;
    assign A        = a_q;
    assign E        = e_q;
    assign OPERAND  = ir_q[ADDR_W-1:0];
    assign HALTED   = halted_q;
    assign RETIRED  = retired_q;

endmodule
`default_nettype wire
